// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 sliding-window generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

  localparam int PIX_W = 64;
  localparam int WIN_N = 9;

  // Window slot indices, row-major, row 0 / column 0 are the oldest.
  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MC = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t win_t [WIN_N];

  typedef enum logic [1:0] {IDLE, RUN, DONE} win_state_e;

endpackage

// File: rtl/lineBuffer.sv
// Row delay: o_pixel is the pixel written exactly curr_width accepted beats earlier.
// Latency: read tap is combinational; delay counted in data_valid beats, not cycles.
// Backpressure: none; gaps (data_valid=0) freeze pointer and contents.
module lineBuffer
  import conv_pkg::*;
#(
  parameter int MAX_WIDTH = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] curr_width,
  input  pixel_t      pixel,
  input  logic        data_valid,
  output pixel_t      o_pixel
);

  localparam int AW = $clog2(MAX_WIDTH);

  pixel_t          mem [MAX_WIDTH];
  logic [AW-1:0]   ptr;
  logic [AW-1:0]   last;

  assign last    = AW'(curr_width - 32'd1);
  // Read-before-write at the same slot gives the W-beat delay.
  assign o_pixel = mem[ptr];

  // Circular pointer wrapping at the active row length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (data_valid) begin
      ptr <= (ptr == last) ? '0 : ptr + 1'b1;
    end
  end

  // Storage needs no reset: stale rows never reach an emitted window.
  always_ff @(posedge clk) begin
    if (data_valid) begin
      mem[ptr] <= pixel;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream, stride 1 or 2, valid-mode.
// Latency: window registered 1 clk after the beat completing it.
// Backpressure: none; input gaps freeze all state, beats during DONE are dropped.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int MAX_WIDTH  = 128,
  parameter int MAX_HEIGHT = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          curr_width,
  input  logic [31:0]          curr_height,
  input  logic                 stride2,
  input  logic [PIX_W-1:0]     pixel,
  input  logic                 data_valid,
  output logic [9*PIX_W-1:0]   o_win,
  output logic                 o_valid,
  output logic                 o_frame_done
);

  localparam int CW = $clog2(MAX_WIDTH);
  localparam int RW = $clog2(MAX_HEIGHT);

  win_state_e          state, state_nxt;
  logic [CW-1:0]       col, w_last_q, w_last;
  logic [RW-1:0]       row, h_last_q, h_last;
  logic [31:0]         w_q, w_len;
  logic                s2_q;
  logic                accept, start, last_beat, emit;
  pixel_t              lb1_out, lb2_out;
  pixel_t              tap [3];
  pixel_t              d1  [3];
  pixel_t              d2  [3];
  win_t                win_nxt;
  logic [9*PIX_W-1:0]  win_flat;

  // On the first beat the geometry registers are not loaded yet, so use the live inputs.
  assign w_last    = start ? CW'(curr_width - 32'd1)  : w_last_q;
  assign h_last    = start ? RW'(curr_height - 32'd1) : h_last_q;
  assign w_len     = start ? curr_width : w_q;
  assign last_beat = (col == w_last) && (row == h_last);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (data_valid) state_nxt = RUN;
      RUN:     if (data_valid && last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM control strobes: beats are accepted in IDLE (frame start) and RUN only.
  always_comb begin
    accept = 1'b0;
    start  = 1'b0;
    case (state)
      IDLE: begin
        accept = data_valid;
        start  = data_valid;
      end
      RUN:     accept = data_valid;
      default: ;
    endcase
  end

  // Geometry is frozen at frame start; mid-frame input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_last_q <= '0;
      h_last_q <= '0;
      w_q      <= '0;
      s2_q     <= 1'b0;
    end else if (start) begin
      w_last_q <= w_last;
      h_last_q <= h_last;
      w_q      <= curr_width;
      s2_q     <= stride2;
    end
  end

  // Raster position of the beat being accepted; row holds at H-1 until DONE clears both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (state == DONE) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == w_last) begin
        col <= '0;
        if (row != h_last) row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  lineBuffer #(.MAX_WIDTH(MAX_WIDTH)) u_lb1 (
    .clk        (clk),
    .rst        (rst),
    .curr_width (w_len),
    .pixel      (pixel),
    .data_valid (accept),
    .o_pixel    (lb1_out)
  );

  lineBuffer #(.MAX_WIDTH(MAX_WIDTH)) u_lb2 (
    .clk        (clk),
    .rst        (rst),
    .curr_width (w_len),
    .pixel      (lb1_out),
    .data_valid (accept),
    .o_pixel    (lb2_out)
  );

  assign tap[0] = lb2_out;
  assign tap[1] = lb1_out;
  assign tap[2] = pixel;

  // Column history: the live tap is the newest column, so two registers per row suffice.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        d2[r] <= d1[r];
        d1[r] <= tap[r];
      end
    end
  end

  // A window completes on a beat at row>=2, col>=2; stride 2 keeps even positions only.
  assign emit = accept && (row >= RW'(2)) && (col >= CW'(2)) &&
                (!s2_q || (!row[0] && !col[0]));

  // Assemble the window including the beat currently being accepted.
  always_comb begin
    win_nxt[WIN_TL] = d2[0];
    win_nxt[WIN_TC] = d1[0];
    win_nxt[WIN_TR] = tap[0];
    win_nxt[WIN_ML] = d2[1];
    win_nxt[WIN_MC] = d1[1];
    win_nxt[WIN_MR] = tap[1];
    win_nxt[WIN_BL] = d2[2];
    win_nxt[WIN_BC] = d1[2];
    win_nxt[WIN_BR] = tap[2];
  end

  // Flatten window slots onto the output bus, slot i at bits [i*PIX_W +: PIX_W].
  always_comb begin
    win_flat = '0;
    for (int i = 0; i < WIN_N; i++) begin
      win_flat[i*PIX_W +: PIX_W] = win_nxt[i];
    end
  end

  // Output registers: o_win holds the last emitted window between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_win        <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_valid      <= emit;
      o_frame_done <= (state == DONE);
      if (emit) o_win <= win_flat;
    end
  end

endmodule
